// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl : command sequencer / tick prescaler for the MM:SS BCD chain
// rev 1.0
// ============================================================================
module stopwatch_ctrl #(
  parameter int TICK_DIV = 16,
  parameter int SPD_MAX  = 3
) (
  input  logic       clk_in,
  input  logic       RESET,
  input  logic       START,
  input  logic       REVERSE,
  input  logic       SPEED_UP,
  input  logic       SPEED_DOWN,
  input  logic       ADD,
  input  logic       SUBTRACT,
  input  logic       CLEAR,
  input  logic       AT_LIMIT,
  output logic       tick,
  output logic       count_down,
  output logic       step_up,
  output logic       step_down,
  output logic       load,
  output logic       preset_sel,
  output logic [1:0] speed,
  output logic [1:0] err_code,
  output logic [2:0] state
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [1:0]  ERR_NONE = 2'b00;
  localparam logic [1:0]  ERR_DIR  = 2'b01;
  localparam logic [1:0]  ERR_SPD  = 2'b10;
  localparam logic [1:0]  ERR_CMD  = 2'b11;
  localparam logic [1:0]  SPD_TOP  = 2'(SPD_MAX);
  localparam logic [31:0] DIV32    = 32'(TICK_DIV);

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d, period_m1;
  logic [4:0]      hist_q;
  logic            cd_d, tick_d, up_d, dn_d, ld_d, ps_d;
  logic [1:0]      speed_d, err_d;
  logic            e_spu, e_spd, e_add, e_sub, e_clr;
  logic            cmd_win, run_ok, spd_win;
  logic            spd_inc, spd_dec, spd_sat, spd_chg, accepted;

  always_ff @(posedge clk_in) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      hist_q     <= '0;
      count_down <= 1'b0;
      speed      <= 2'd0;
      err_code   <= ERR_NONE;
      tick       <= 1'b0;
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      load       <= 1'b0;
      preset_sel <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      hist_q     <= {CLEAR, SUBTRACT, ADD, SPEED_DOWN, SPEED_UP};
      count_down <= cd_d;
      speed      <= speed_d;
      err_code   <= err_d;
      tick       <= tick_d;
      step_up    <= up_d;
      step_down  <= dn_d;
      load       <= ld_d;
      preset_sel <= ps_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cd_d      = count_down;
    speed_d   = speed;
    err_d     = err_code;
    tick_d    = 1'b0;
    up_d      = 1'b0;
    dn_d      = 1'b0;
    ld_d      = 1'b0;
    ps_d      = 1'b0;
    cmd_win   = 1'b0;
    run_ok    = 1'b0;

    e_spu     = SPEED_UP   & ~hist_q[0];
    e_spd     = SPEED_DOWN & ~hist_q[1];
    e_add     = ADD        & ~hist_q[2];
    e_sub     = SUBTRACT   & ~hist_q[3];
    e_clr     = CLEAR      & ~hist_q[4];

    period_m1 = PW'((DIV32 >> speed) - 32'd1);
    spd_inc   = e_spu & ~e_spd;
    spd_dec   = e_spd & ~e_spu;
    spd_sat   = (spd_inc && speed == SPD_TOP) || (spd_dec && speed == 2'd0);
    spd_chg   = (spd_inc | spd_dec) & ~spd_sat;

    case (state_q)
      S_IDLE: begin
        cmd_win = 1'b1;
        if (START) begin
          state_d = S_RUN;
          cd_d    = REVERSE;
          presc_d = '0;
        end
      end
      S_RUN: begin
        if (AT_LIMIT) begin
          state_d = S_DONE;
        end else if (!START) begin
          state_d = S_PAUSE;
        end else if (REVERSE != count_down) begin
          state_d = S_ERROR;
          err_d   = ERR_DIR;
        end else begin
          run_ok = 1'b1;
          // >= rather than == so a held value above a shorter new period still wraps
          if (presc_q >= period_m1) begin
            presc_d = '0;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        cmd_win = 1'b1;
        if (START) begin
          state_d = S_RUN;
          cd_d    = REVERSE;
        end
      end
      S_DONE: begin
        cmd_win = 1'b1;
        if (e_clr) begin
          state_d = START ? S_PAUSE : S_IDLE;
        end else if (!START) begin
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        if (!START) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    spd_win = cmd_win | run_ok;

    if (cmd_win) begin
      up_d = e_add & ~e_sub;
      dn_d = e_sub & ~e_add;
      ld_d = e_clr;
      ps_d = e_clr & REVERSE;
    end

    if (spd_win && spd_chg) begin
      speed_d = spd_inc ? speed + 2'd1 : speed - 2'd1;
      if (state_q == S_RUN) begin
        presc_d = '0;
        tick_d  = 1'b0;
      end
    end

    // Accepted commands clear a sticky code; a new conflict in the same cycle wins.
    accepted = up_d | dn_d | ld_d | (spd_win & spd_chg);
    if (accepted) begin
      err_d = ERR_NONE;
    end
    if (cmd_win && e_add && e_sub) begin
      err_d = ERR_CMD;
    end
    if (spd_win && spd_sat) begin
      err_d = ERR_SPD;
    end
    if (state_q != S_IDLE && state_d == S_IDLE) begin
      err_d = ERR_NONE;
    end
  end

endmodule
`default_nettype wire
